// File: rtl/matrix_loader.sv
// matrix_loader: assembles a serial element stream into flat A/B operand buses, holds the pair for downstream.
// Define MATB_COLMAJOR_EN to stream operand B column-major; A is always row-major.
module matrix_loader #(
  parameter int N     = 3,
  parameter int width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [width-1:0]       in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [N*N*width-1:0]   mata,
  output logic [N*N*width-1:0]   matb,
  output logic                   mat_valid,
  input  logic                   mat_ready,
  output logic                   frame_err
);
  localparam int CW = (N*N > 1) ? $clog2(N*N) : 1;
  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] slot_b;
  logic          last_el;
  logic          fin;
  assign in_ready  = state != HOLD;
  assign mat_valid = state == HOLD;
  assign last_el   = cnt == CW'(N*N-1);
  assign fin       = state == LOAD_B && last_el;
`ifdef MATB_COLMAJOR_EN
  assign slot_b = CW'((int'(cnt) % N) * N + int'(cnt) / N);
`else
  assign slot_b = cnt;
`endif
  // in_last must coincide exactly with the final B element; any mismatch drops the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD_A;
      cnt       <= '0;
      mata      <= '0;
      matb      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state == HOLD) begin
        if (mat_ready) state <= LOAD_A;
      end else if (in_valid) begin
        if (state == LOAD_A) mata[int'(cnt)*width +: width] <= in_data;
        else matb[int'(slot_b)*width +: width] <= in_data;
        if (in_last != fin) begin
          frame_err <= 1'b1;
          state     <= LOAD_A;
          cnt       <= '0;
        end else if (last_el) begin
          cnt   <= '0;
          state <= (state == LOAD_A) ? LOAD_B : HOLD;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: table-driven pair loads with a scoreboard of expected operand buses, plus framing/reset corner sequences.
module tb_matrix_loader;
  localparam int N = 3;
  localparam int W = 8;
  localparam int BW = N*N*W;
`ifdef MATB_COLMAJOR_EN
  localparam bit COLMAJ = 1'b1;
`else
  localparam bit COLMAJ = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_last = 1'b0;
  logic in_ready;
  logic [BW-1:0] mata, matb;
  logic mat_valid;
  logic mat_ready = 1'b0;
  logic frame_err;
  int checks = 0;
  int errors = 0;
  int stream[18];
  typedef struct {
    int a0, ad, b0, bd;
    bit gaps;
    int stall, pre_err;
    int a00, a22, b00, b22;
  } vec_t;
  typedef struct {
    logic [BW-1:0] a, b;
  } pair_t;
  vec_t tab[4];
  pair_t sb[$];
  pair_t exp_p;

  matrix_loader #(.N(N), .width(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mata(mata), .matb(matb), .mat_valid(mat_valid),
    .mat_ready(mat_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack(input int v0, input int d, input bit cm);
    logic [BW-1:0] m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int k = cm ? c*N + r : r*N + c;
        m[(r*N+c)*W +: W] = W'(v0 + d*k);
      end
    return m;
  endfunction

  task automatic fill(input int a0, input int ad, input int b0, input int bd);
    for (int k = 0; k < 9; k++) begin
      stream[k]   = a0 + ad*k;
      stream[9+k] = b0 + bd*k;
    end
  endtask

  // drives n elements at negedges; a handshake is counted when in_valid && in_ready ahead of the next posedge
  task automatic send(input int n, input int last_at, input bit gaps);
    int k = 0;
    int guard = 0;
    bit tog = 1'b1;
    while (k < n && guard < 200) begin
      @(negedge clk);
      guard++;
      chk("frame_err_idle", frame_err, 0);
      in_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      in_data = W'(stream[k]);
      in_last = (k == last_at);
      if (in_valid && in_ready) k++;
    end
    if (k < n) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got %0d handshakes expected %0d", k, n);
    end
  endtask

  initial begin
    tab[0] = '{1, 1, 9, -1, 1'b0, 0, 0, 1, 9, 9, 1};
    tab[1] = '{1, 1, 9, -1, 1'b0, 5, 0, 1, 9, 9, 1};
    tab[2] = '{1, 1, 9, -1, 1'b1, 0, 0, 1, 9, 9, 1};
    tab[3] = '{2, 1, 1, 1, 1'b0, 0, 5, 2, 10, 1, 9};
    repeat (3) @(negedge clk);
    chk("rst_mata", mata, 0);
    chk("rst_matb", matb, 0);
    chk("rst_mat_valid", mat_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (tab[t].pre_err > 0) begin
        fill(8'hEE, 0, 8'hEE, 0);
        send(tab[t].pre_err, tab[t].pre_err - 1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("early_last_err", frame_err, 1);
        chk("early_last_valid", mat_valid, 0);
        chk("early_last_ready", in_ready, 1);
        @(negedge clk);
        chk("early_last_pulse", frame_err, 0);
      end
      fill(tab[t].a0, tab[t].ad, tab[t].b0, tab[t].bd);
      sb.push_back('{pack(tab[t].a0, tab[t].ad, 1'b0), pack(tab[t].b0, tab[t].bd, COLMAJ)});
      mat_ready = (tab[t].stall == 0);
      send(18, 17, tab[t].gaps);
      @(negedge clk);
      in_valid = (tab[t].stall > 0);
      in_data = 8'hFF;
      in_last = 1'b0;
      chk("pair_valid", mat_valid, 1);
      chk("pair_in_ready", in_ready, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        exp_p = sb.pop_front();
        chk("pair_mata", mata, exp_p.a);
        chk("pair_matb", matb, exp_p.b);
      end
      chk("a00", mata[7:0], tab[t].a00);
      chk("a22", mata[71:64], tab[t].a22);
      chk("b00", matb[7:0], tab[t].b00);
      chk("b22", matb[71:64], tab[t].b22);
      for (int i = 1; i < tab[t].stall; i++) begin
        @(negedge clk);
        chk("stall_valid", mat_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_mata", mata, exp_p.a);
        chk("stall_matb", matb, exp_p.b);
      end
      mat_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("release_valid", mat_valid, 0);
      chk("release_in_ready", in_ready, 1);
    end
    fill(1, 1, 9, -1);
    send(18, -1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("miss_last_err", frame_err, 1);
    chk("miss_last_valid", mat_valid, 0);
    @(negedge clk);
    chk("miss_last_pulse", frame_err, 0);
    chk("miss_last_valid2", mat_valid, 0);
    stream[0] = 8'h5A;
    send(1, -1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("miss_last_slot0", mata[7:0], 8'h5A);
    chk("miss_last_keep", mata[15:8], 2);
    fill(1, 1, 1, 1);
    send(12, -1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_mata", mata, 0);
    chk("midrst_matb", matb, 0);
    chk("midrst_valid", mat_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{pack(1, 1, 1'b0), pack(1, 1, COLMAJ)});
    send(18, 17, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("post_rst_valid", mat_valid, 1);
    exp_p = sb.pop_front();
    chk("post_rst_mata", mata, exp_p.a);
    chk("post_rst_matb", matb, exp_p.b);
    chk("post_rst_a00", mata[7:0], 1);
    chk("post_rst_b01", matb[15:8], COLMAJ ? 4 : 2);
    @(negedge clk);
    chk("post_rst_release", mat_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream feeder for the matrix-multiply stage.
- Accepts a serial element stream over a valid/ready handshake and assembles operand A, then operand B, into the flat N*N*width buses the multiplier consumes.
- Holds the completed pair stable and presents it with a valid/ready handshake.
- Checks stream framing against an end-of-pair marker.

Parameters:
- N, 3, matrix dimension (N x N operands).
- width, 8, bits per element.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: 0 = in reset.
- in_valid  input  1  input element valid.
- in_data  input  width  input element value.
- in_last  input  1  marks the final element of an A+B pair (element 2*N*N-1).
- in_ready  output  1  loader can accept an element.
- mata  output  N*N*width  operand A, flat.
- matb  output  N*N*width  operand B, flat.
- mat_valid  output  1  mata/matb hold a complete pair.
- mat_ready  input  1  downstream accepts the pair.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Handshakes:
  - Input handshake = in_valid && in_ready at a rising clk edge.
  - Output handshake = mat_valid && mat_ready at a rising clk edge.
- Packing: element (r,c) occupies bits [(r*N+c)*width +: width], so (0,0) is in the LSBs. Stream order is row-major: index k maps to r=k/N, c=k%N.
- Reset (reset=0, asynchronous):
  - State LOAD_A, element counter 0.
  - mata=0, matb=0, mat_valid=0, frame_err=0.
  - in_ready=1 once state is LOAD_A.
  - Any partial frame is discarded.
- in_ready is decoded from registered state only and never depends on in_valid. It is 1 in LOAD_A and LOAD_B, and 0 in HOLD.
- Counter: ceil(log2(N*N)) bits, range 0..N*N-1. Increments only on an input handshake. Wraps to 0 when leaving a LOAD state.
- LOAD_A:
  - Each input handshake writes in_data into the mata slot at the current counter value.
  - The handshake at counter N*N-1 moves to LOAD_B with counter 0.
- LOAD_B:
  - Same as LOAD_A, but writes into matb.
  - The handshake at counter N*N-1 (with valid framing) moves to HOLD.
- HOLD:
  - mat_valid=1, registered: it rises the cycle after the final B handshake.
  - mata and matb are bit-stable.
  - in_data and in_valid are ignored.
  - An output handshake returns the loader to LOAD_A; mat_valid=0 and in_ready=1 from the next cycle.
  - There is no same-cycle bypass.
- Minimum period per pair: 2*N*N + 1 cycles.
- mata/matb change progressively while loading. Downstream samples them only while mat_valid=1.
- mat_ready is ignored when mat_valid=0.
- Framing:
  - in_last=1 on any handshake other than the final B element: frame_err pulses 1 cycle, and the next state is LOAD_A with counter 0.
  - in_last=0 on the final B element: same error response. The pair is dropped and mat_valid stays 0.
  - mata and matb are not cleared on an error.
  - frame_err is registered and is 0 in every other cycle.
- Arithmetic: none. Element values pass through unmodified at full width.

Optional Feature:
- Macro: MATB_COLMAJOR_EN.
- Defined: operand B is streamed column-major. B index k maps to r=k%N, c=k/N. A remains row-major.
- Undefined: B is row-major, identical to A.
- Bus packing, timing and framing are unaffected in both cases.

Test Plan:
1. Nominal pair (N=3, width=8):
   - Stimulus: reset pulse; stream A=1..9 then B=9..1 with in_valid held high; in_last on the 18th element; mat_ready=1.
   - Response: mata[7:0]=1 and mata[71:64]=9; matb[7:0]=9 and matb[71:64]=1.
   - Response: mat_valid high exactly 1 cycle, starting the cycle after the 18th handshake; then in_ready=1.
2. Backpressure:
   - Stimulus: same stream as scenario 1, but mat_ready=0 for 5 cycles after mat_valid rises; in_valid=1 with in_data=0xFF throughout.
   - Response: in_ready=0, mata/matb unchanged and mat_valid=1 throughout; release occurs on the cycle mat_ready=1.
3. Input gaps:
   - Stimulus: in_valid toggled every other cycle.
   - Response: same buses as scenario 1; the counter advances only on handshakes.
4. Early in_last:
   - Stimulus: in_last on the 5th element.
   - Response: frame_err pulses 1 cycle; no mat_valid; a following clean frame of A=2..10, B=1..9 is delivered correctly (mata[7:0]=2).
5. Missing in_last:
   - Stimulus: in_last=0 on the 18th element.
   - Response: frame_err pulses; mat_valid stays 0; the next element is written to mata slot 0.
6. Reset mid-operation:
   - Stimulus: reset=0 asserted after 12 handshakes (during LOAD_B), between clock edges.
   - Response: mata=matb=0 and mat_valid=0 immediately; after release, the next stream loads from A(0,0).
   - With MATB_COLMAJOR_EN: B stream 1..9 gives B(0,1)=4, i.e. matb[15:8]=4.
